// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory read channel between the fetch stage and memory.
//   imem_req_valid  fetch -> mem   read request valid
//   imem_req_ready  mem -> fetch   memory accepts the request
//   imem_addr       fetch -> mem   read address
//   imem_rsp_valid  mem -> fetch   read data valid
//   imem_rdata      mem -> fetch   read data
// Modports: master (fetch stage side), slave (memory side).
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req_valid,
    output imem_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req_valid,
    input  imem_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Holds the PC, issues one instruction-memory
// read at a time, captures the returned word and presents it downstream until retired.
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   imem                   instruction-memory channel (fetch_unit_if.master)
//   instr_valid/ready      downstream handshake; retire on valid & ready
//   Instr, op, funct3, funct7b5   captured instruction and its decoded fields
//   PC, PCPlus4            address of Instr and PC + 4 (mod 2^32)
//   PCSrc, PCTarget        next-PC select and target, sampled at retire only
//   instret                retired-instruction counter (wraps)
//   fetch_err              sticky error flag (misaligned target / unsolicited response)
//
// state | meaning
// IDLE  | reset state, moves to REQ on first clock after reset release
// REQ   | request for PC held on imem until accepted
// WAIT  | request accepted, waiting for the single outstanding response
// HOLD  | Instr presented downstream until instr_ready
// HALT  | error; outputs quiet, fetch_err high, left only by reset
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         reset_n,
  fetch_unit_if.master imem,
  output logic         instr_valid,
  input  logic         instr_ready,
  output logic [31:0]  Instr,
  output logic [6:0]   op,
  output logic [2:0]   funct3,
  output logic         funct7b5,
  output logic [31:0]  PC,
  output logic [31:0]  PCPlus4,
  input  logic         PCSrc,
  input  logic [31:0]  PCTarget,
  output logic [31:0]  instret,
  output logic         fetch_err
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    HALT = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instret_q, instret_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= NOP;
      instret_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    instret_d = instret_q;
    case (state_q)
      IDLE: begin
        if (imem.imem_rsp_valid) state_d = HALT;
        else                     state_d = REQ;
      end
      REQ: begin
        // a response here cannot belong to this request: it is only accepted in WAIT
        if (imem.imem_rsp_valid)      state_d = HALT;
        else if (imem.imem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (imem.imem_rsp_valid) begin
          instr_d = imem.imem_rdata;
          state_d = HOLD;
        end
      end
      HOLD: begin
        // an unsolicited response wins over a simultaneous retire
        if (imem.imem_rsp_valid) begin
          state_d = HALT;
        end else if (instr_ready) begin
          instret_d = instret_q + 32'd1;
          if (PCSrc && (PCTarget[1:0] != 2'b00)) begin
            state_d = HALT;
          end else begin
            pc_d    = PCSrc ? PCTarget : PCPlus4;
            state_d = REQ;
          end
        end
      end
      HALT:    state_d = HALT;
      default: state_d = HALT;
    endcase
  end

  // HALT is only left by reset, so the sticky flag is simply the HALT decode
  assign imem.imem_req_valid = (state_q == REQ);
  assign imem.imem_addr      = pc_q;
  assign instr_valid         = (state_q == HOLD);
  assign fetch_err           = (state_q == HALT);
  assign Instr               = instr_q;
  assign op                  = instr_q[6:0];
  assign funct3              = instr_q[14:12];
  assign funct7b5            = instr_q[30];
  assign PC                  = pc_q;
  assign PCPlus4             = pc_q + 32'd4;
  assign instret             = instret_q;

endmodule
